// File: rtl/down_counter_pkg.sv
// Shared types and constants for the down_counter block.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package down_counter_pkg;

    // Default count width in bits; legal range is 2..16.
    localparam int unsigned DC_WIDTH_DEFAULT = 4;

    // Counter control states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } dc_state_e;

endpackage : down_counter_pkg

// File: rtl/down_counter.sv
// Loadable down counter with enable, busy flag and a one-cycle terminal-count pulse.
// Latency: load visible on q the next cycle; the first decrement follows one cycle later.
// Backpressure: none; en pauses the count, and load always wins over en.
// Optional feature: define DOWN_COUNTER_AUTORELOAD_EN to add reload_en and a periodic reload register.
module down_counter
    import down_counter_pkg::*;
#(
    parameter int WIDTH = DC_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
`ifdef DOWN_COUNTER_AUTORELOAD_EN
    input  logic             reload_en,
`endif
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             tc
);

    localparam logic [WIDTH-1:0] CNT_ZERO = '0;
    localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);

    dc_state_e        state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             tc_q, tc_d;
`ifdef DOWN_COUNTER_AUTORELOAD_EN
    logic [WIDTH-1:0] reload_q, reload_d;
`endif

    // Next-state logic: load has priority, then the enabled decrement in RUN.
    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        tc_d    = 1'b0;
`ifdef DOWN_COUNTER_AUTORELOAD_EN
        reload_d = reload_q;
`endif
        if (load) begin
            // A load always restarts the count, even on the terminal cycle,
            // so the pulse for the old count is suppressed.
            q_d     = load_val;
            state_d = (load_val != CNT_ZERO) ? RUN : DONE;
`ifdef DOWN_COUNTER_AUTORELOAD_EN
            reload_d = load_val;
`endif
        end else if ((state_q == RUN) && en) begin
            if (q_q == CNT_ONE) begin
                tc_d = 1'b1;
`ifdef DOWN_COUNTER_AUTORELOAD_EN
                if (reload_en) begin
                    // Period of N cycles: jump from 1 straight back to N, never showing 0.
                    q_d     = reload_q;
                    state_d = RUN;
                end else begin
                    q_d     = CNT_ZERO;
                    state_d = DONE;
                end
`else
                q_d     = CNT_ZERO;
                state_d = DONE;
`endif
            end else if (q_q == CNT_ZERO) begin
                // Not reachable through load; park safely instead of wrapping.
                state_d = DONE;
            end else begin
                q_d = q_q - CNT_ONE;
            end
        end
    end

    // State register with synchronous reset that overrides load and en.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            q_q     <= CNT_ZERO;
            tc_q    <= 1'b0;
`ifdef DOWN_COUNTER_AUTORELOAD_EN
            reload_q <= CNT_ZERO;
`endif
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            tc_q    <= tc_d;
`ifdef DOWN_COUNTER_AUTORELOAD_EN
            reload_q <= reload_d;
`endif
        end
    end

    assign q    = q_q;
    assign busy = (state_q == RUN);
    assign tc   = tc_q;

endmodule : down_counter

// File: tb/tb_down_counter.sv
// Directed self-checking bench for down_counter (default WIDTH=4).
// Inputs change #1 after a rising edge; outputs are checked at that same point.
// Define DOWN_COUNTER_AUTORELOAD_EN to also exercise the periodic reload mode.
module tb_down_counter;

    logic       clk;
    logic       reset;
    logic       load;
    logic [3:0] load_val;
    logic       en;
    logic [3:0] q;
    logic       busy;
    logic       tc;
`ifdef DOWN_COUNTER_AUTORELOAD_EN
    logic       reload_en;
`endif

    int checks;
    int errors;

    down_counter #(.WIDTH(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .load_val (load_val),
        .en       (en),
`ifdef DOWN_COUNTER_AUTORELOAD_EN
        .reload_en(reload_en),
`endif
        .q        (q),
        .busy     (busy),
        .tc       (tc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle away from it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; load = 1'b0; en = 1'b0;
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        // Reset must dominate a simultaneous load and enable.
        reset = 1'b1; load = 1'b1; load_val = 4'd9; en = 1'b1;
        step();
        reset = 1'b0; load = 1'b0;
        checks++; if (q !== 4'd0)  begin errors++; $display("FAIL reset_q got=%0d exp=0", q); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%0b exp=0", busy); end
        checks++; if (tc !== 1'b0)  begin errors++; $display("FAIL reset_tc got=%0b exp=0", tc); end
        // IDLE with en high holds at 0.
        en = 1'b1;
        step();
        checks++; if (q !== 4'd0 || busy !== 1'b0) begin errors++; $display("FAIL idle_hold q=%0d busy=%0b exp q=0 busy=0", q, busy); end
    endtask

    task automatic test_count5();
        logic [3:0] exp_q [6]  = '{4'd5, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0};
        logic       exp_b [6]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic       exp_t [6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        do_reset();
        load = 1'b1; load_val = 4'd5; en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            load = 1'b0;
            checks++;
            if (q !== exp_q[i] || busy !== exp_b[i] || tc !== exp_t[i]) begin
                errors++;
                $display("FAIL count5[%0d] got q=%0d busy=%0b tc=%0b exp q=%0d busy=%0b tc=%0b",
                         i, q, busy, tc, exp_q[i], exp_b[i], exp_t[i]);
            end
        end
        // DONE holds at 0, no wrap, tc not repeated.
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (q !== 4'd0 || busy !== 1'b0 || tc !== 1'b0) begin
                errors++;
                $display("FAIL count5_done[%0d] got q=%0d busy=%0b tc=%0b exp q=0 busy=0 tc=0", i, q, busy, tc);
            end
        end
    endtask

    task automatic test_en_toggle();
        logic       en_seq [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [3:0] exp_q  [5] = '{4'd2, 4'd2, 4'd1, 4'd1, 4'd0};
        logic       exp_t  [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        int pulses = 0;
        do_reset();
        load = 1'b1; load_val = 4'd3; en = 1'b1;
        step();
        load = 1'b0;
        checks++; if (q !== 4'd3) begin errors++; $display("FAIL toggle_load got=%0d exp=3", q); end
        for (int i = 0; i < 5; i++) begin
            en = en_seq[i];
            step();
            if (tc === 1'b1) pulses++;
            checks++;
            if (q !== exp_q[i] || tc !== exp_t[i]) begin
                errors++;
                $display("FAIL toggle[%0d] got q=%0d tc=%0b exp q=%0d tc=%0b", i, q, tc, exp_q[i], exp_t[i]);
            end
        end
        en = 1'b0;
        step();
        if (tc === 1'b1) pulses++;
        checks++; if (pulses != 1) begin errors++; $display("FAIL toggle_pulses got=%0d exp=1", pulses); end
    endtask

    task automatic test_load_zero();
        int pulses = 0;
        do_reset();
        load = 1'b1; load_val = 4'd0; en = 1'b1;
        step();
        load = 1'b0;
        if (tc === 1'b1) pulses++;
        checks++; if (q !== 4'd0 || busy !== 1'b0) begin errors++; $display("FAIL load0 got q=%0d busy=%0b exp q=0 busy=0", q, busy); end
        for (int i = 0; i < 3; i++) begin
            step();
            if (tc === 1'b1) pulses++;
        end
        checks++; if (pulses != 0 || q !== 4'd0) begin errors++; $display("FAIL load0_tc pulses=%0d q=%0d exp pulses=0 q=0", pulses, q); end
    endtask

    task automatic test_reset_midcount();
        logic [3:0] exp_q [3] = '{4'd2, 4'd1, 4'd0};
        logic       exp_t [3] = '{1'b0, 1'b0, 1'b1};
        do_reset();
        load = 1'b1; load_val = 4'd4; en = 1'b1;
        step();                 // q=4
        load = 1'b0;
        step();                 // q=3
        step();                 // q=2
        checks++; if (q !== 4'd2) begin errors++; $display("FAIL mid_pre got=%0d exp=2", q); end
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++; if (q !== 4'd0 || busy !== 1'b0 || tc !== 1'b0) begin errors++; $display("FAIL mid_reset got q=%0d busy=%0b tc=%0b exp 0/0/0", q, busy, tc); end
        load = 1'b1; load_val = 4'd2;
        for (int i = 0; i < 3; i++) begin
            step();
            load = 1'b0;
            checks++;
            if (q !== exp_q[i] || tc !== exp_t[i]) begin
                errors++;
                $display("FAIL mid_reload[%0d] got q=%0d tc=%0b exp q=%0d tc=%0b", i, q, tc, exp_q[i], exp_t[i]);
            end
        end
    endtask

    task automatic test_load_on_terminal();
        do_reset();
        load = 1'b1; load_val = 4'd1; en = 1'b1;
        step();
        checks++; if (q !== 4'd1 || busy !== 1'b1) begin errors++; $display("FAIL term_pre got q=%0d busy=%0b exp q=1 busy=1", q, busy); end
        load_val = 4'd7;        // load held on the terminal cycle
        step();
        load = 1'b0;
        checks++; if (q !== 4'd7 || tc !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL term_load got q=%0d tc=%0b busy=%0b exp q=7 tc=0 busy=1", q, tc, busy); end
        step();
        checks++; if (q !== 4'd6) begin errors++; $display("FAIL term_next got=%0d exp=6", q); end
    endtask

    task automatic test_load_priority_max();
        do_reset();
        load = 1'b1; load_val = 4'd15; en = 1'b1;
        step();
        checks++; if (q !== 4'd15) begin errors++; $display("FAIL max_load got=%0d exp=15", q); end
        load_val = 4'd9;        // load and en together mid-count: load wins, no decrement
        step();
        load = 1'b0;
        checks++; if (q !== 4'd9) begin errors++; $display("FAIL prio_load got=%0d exp=9", q); end
        step();
        checks++; if (q !== 4'd8) begin errors++; $display("FAIL prio_dec got=%0d exp=8", q); end
    endtask

`ifdef DOWN_COUNTER_AUTORELOAD_EN
    task automatic test_autoreload();
        logic [3:0] exp_q [7] = '{4'd3, 4'd2, 4'd1, 4'd3, 4'd2, 4'd1, 4'd3};
        logic       exp_t [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        logic [3:0] exp_q2 [3] = '{4'd2, 4'd1, 4'd0};
        logic       exp_t2 [3] = '{1'b0, 1'b0, 1'b1};
        do_reset();
        reload_en = 1'b1;
        load = 1'b1; load_val = 4'd3; en = 1'b1;
        for (int i = 0; i < 7; i++) begin
            step();
            load = 1'b0;
            checks++;
            if (q !== exp_q[i] || tc !== exp_t[i] || busy !== 1'b1) begin
                errors++;
                $display("FAIL autoreload[%0d] got q=%0d tc=%0b busy=%0b exp q=%0d tc=%0b busy=1",
                         i, q, tc, busy, exp_q[i], exp_t[i]);
            end
        end
        reload_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (q !== exp_q2[i] || tc !== exp_t2[i]) begin
                errors++;
                $display("FAIL autostop[%0d] got q=%0d tc=%0b exp q=%0d tc=%0b", i, q, tc, exp_q2[i], exp_t2[i]);
            end
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL autostop_busy got=%0b exp=0", busy); end
    endtask
`endif

    initial begin
        checks = 0; errors = 0;
        reset = 1'b0; load = 1'b0; load_val = 4'd0; en = 1'b0;
`ifdef DOWN_COUNTER_AUTORELOAD_EN
        reload_en = 1'b0;
`endif
        #1;
        test_reset();
        test_count5();
        test_en_toggle();
        test_load_zero();
        test_reset_midcount();
        test_load_on_terminal();
        test_load_priority_max();
`ifdef DOWN_COUNTER_AUTORELOAD_EN
        test_autoreload();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_down_counter

// File: doc/down_counter.md
DOWN_COUNTER -- requirements
Module: down_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 4, giving the count width in bits (legal 2..16).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset, sampled on rising clk.
REQ-004 SHALL have port load, input, 1 bit: single-cycle request to start a count.
REQ-005 SHALL have port load_val, input, WIDTH bits: start value, sampled when load=1.
REQ-006 SHALL have port en, input, 1 bit: count enable; q decrements only when en=1.
REQ-007 SHALL have port q, output, WIDTH bits: current count, registered.
REQ-008 SHALL have port busy, output, 1 bit: high while state is RUN.
REQ-009 SHALL have port tc, output, 1 bit: registered one-cycle terminal-count pulse.

Function
REQ-010 SHALL implement FSM states IDLE, RUN and DONE.
REQ-011 Load in any state SHALL set q<=load_val next cycle; state becomes RUN if load_val!=0, else DONE with tc=0.
REQ-012 In RUN with en=1 and load=0, q SHALL decrement by exactly 1 per cycle.
REQ-013 In RUN with en=1 and q==1, q SHALL become 0, tc SHALL be 1 for that single cycle, and state SHALL become DONE (one-shot).
REQ-014 In RUN with en=0, q SHALL hold and tc SHALL stay 0.
REQ-015 In IDLE and DONE, q SHALL hold, busy=0, and q SHALL never wrap below 0.
REQ-016 Simultaneous load and en SHALL give priority to load; no decrement that cycle.
REQ-017 A load on the same cycle as the terminal decrement SHALL win; tc SHALL be 0 and q SHALL equal load_val.
REQ-018 tc SHALL never be high for two consecutive cycles in one-shot mode.
REQ-019 Latency from load to first decrement visible on q SHALL be 2 cycles with en held at 1.

Reset
REQ-020 With reset=1 at a rising clk, the next state SHALL be q=0, busy=0, tc=0 and state IDLE.
REQ-021 Reset SHALL take priority over load and en, including mid-count.

Configuration
REQ-022 Macro DOWN_COUNTER_AUTORELOAD_EN, when defined, SHALL add input reload_en (1 bit) and an internal WIDTH-bit reload register, captured from load_val on every load.
REQ-023 With the macro defined, reload_en=1 and the terminal condition met, q SHALL become the reload register value, tc SHALL pulse, and state SHALL stay RUN; the period is N cycles and q never shows 0.
REQ-024 With the macro defined and reload_en=0, behaviour SHALL match REQ-013.
REQ-025 Without the macro, the reload_en port and reload register SHALL not exist, and behaviour is one-shot only.
REQ-026 Reset SHALL clear the reload register to 0.

Structure
REQ-027 A shared package down_counter_pkg SHALL hold the state enum typedef (IDLE, RUN, DONE) and the WIDTH default constant.
REQ-028 The block SHALL be a single module; no sub-module is required.

Verification
REQ-029 Reset, then load=1 with load_val=5 and en=1 -> q goes 5,4,3,2,1,0; tc=1 only on the cycle q=0; busy falls with it.
REQ-030 Load 3 and toggle en 1,0,1,0,1 -> q goes 3,2,2,1,1,0; tc pulses once.
REQ-031 Load 0 -> q=0, state DONE, busy=0, tc never asserts.
REQ-032 Load 4, then at q=2 assert reset -> q=0 and busy=0 next cycle; a later load 2 counts normally.
REQ-033 Load 1 with en=1, then load 7 on the terminal cycle -> tc=0 and q=7.
REQ-034 With DOWN_COUNTER_AUTORELOAD_EN defined, reload_en=1 and load 3 -> q sequence 3,2,1,3,2,1...; tc pulses every 3 cycles; dropping reload_en stops the count at 0.
